fir_serial: RTL and testbench
=============================

FIR_SERIAL -- requirements
Module: fir_serial

Interface
REQ-001 Parameter NTAPS, default 32, tap count (>=2, not required to be a power of two).
REQ-002 Parameter DW, default 16, signed sample and output width.
REQ-003 Parameter CW, default 20, signed coefficient width.
REQ-004 Parameter FRAC, default 16, fractional bits removed from the accumulator at output (>=1).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  sample offered.
REQ-008 in_ready  out  1  block accepts a sample this cycle.
REQ-009 in_data  in  DW  signed input sample.
REQ-010 coef_we  in  1  coefficient write strobe.
REQ-011 coef_addr  in  clog2(NTAPS)  coefficient index k.
REQ-012 coef_data  in  CW  signed coefficient value.
REQ-013 out_valid  out  1  one-cycle pulse; out_data/out_sat hold a new result.
REQ-014 out_data  out  DW  rounded, saturated filter output.
REQ-015 out_sat  out  1  result was clipped.

Function
REQ-016 The block SHALL compute y[n] = sum over k=0..NTAPS-1 of c[k]*x[n-k] with one serial multiply-accumulate per cycle.
REQ-017 The FSM SHALL have three states: IDLE, MAC and ROUND.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 Sample acceptance SHALL occur at the edge where in_valid&&in_ready; that edge writes in_data to the ring buffer at wr_ptr, clears acc, sets k=0 and enters MAC.
REQ-020 Each MAC edge SHALL add x[(wr_ptr-k) mod NTAPS]*c[k] to acc and increment k; after the k=NTAPS-1 edge the FSM SHALL enter ROUND.
REQ-021 The ROUND edge SHALL register out_data/out_sat, pulse out_valid for one cycle and return to IDLE.
REQ-022 out_valid SHALL be visible NTAPS+1 edges after the acceptance edge; minimum acceptance interval SHALL be NTAPS+2 edges.
REQ-023 out_data and out_sat SHALL hold their values until the next out_valid.
REQ-024 acc SHALL be signed, DW+CW+clog2(NTAPS) bits wide, and SHALL never overflow.
REQ-025 Output SHALL be (acc + 2^(FRAC-1)) arithmetically shifted right by FRAC (round half up), then saturated to [-2^(DW-1), 2^(DW-1)-1]; out_sat=1 iff clipped.
REQ-026 The ring pointer SHALL wrap from NTAPS-1 to 0; tap indexing SHALL wrap modulo NTAPS.
REQ-027 A fill counter SHALL count accepted samples, saturating at NTAPS; out_valid SHALL be suppressed (result discarded) while fill count < NTAPS after the current acceptance.
REQ-028 A coefficient write SHALL take effect only when coef_we=1 in IDLE with no acceptance on the same edge; otherwise it is ignored.
REQ-029 A coef_addr >= NTAPS SHALL be ignored.

Reset
REQ-030 While rst_n=0: FSM=IDLE, ring buffer, all coefficients, acc, k, wr_ptr and fill counter SHALL be 0, out_valid=0, out_data=0, out_sat=0; in_ready=1 after release.
REQ-031 Reset asserted mid-MAC or ROUND SHALL abort the operation with no out_valid pulse.

Structure
REQ-032 Package fir_pkg SHALL hold the state enum, the accumulator-width function and the rounding-constant function.
REQ-033 Rounding and saturation SHALL be a combinational sub-module, fir_round_sat.

Verification (NTAPS=4, DW=16, CW=20, FRAC=16)
REQ-034 Impulse: c = 0x10000, 0x08000, 0x04000, 0x02000; input 0, 0, 0, 0x1000, 0, 0, 0 -> first out_valid on 4th sample, out_data = 0x1000, 0x0800, 0x0400, 0x0200; no earlier pulses.
REQ-035 Saturation: all c=0x10000; input 0x7FFF x4 -> 0x7FFF, out_sat=1; input 0x8000 x4 -> 0x8000, out_sat=1.
REQ-036 Rounding: c0=0x08000, others 0, after 4 priming zeros -> input 3 gives 2, input -3 gives 0xFFFF, out_sat=0.
REQ-037 Handshake: in_valid held high -> acceptances exactly 6 edges apart, in_ready low during MAC/ROUND, sample sequence unchanged.
REQ-038 Coefficient write during MAC -> ignored; results unchanged; the same write in IDLE takes effect on the next sample.
REQ-039 rst_n pulsed low during MAC -> no out_valid, outputs 0, and the next 3 samples produce no out_valid.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the serial FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_ROUND
    } fir_state_e;

    // Width that holds NTAPS full-scale products without overflow.
    function automatic int acc_width(int dw, int cw, int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction

    function automatic logic [63:0] round_const(int frac);
        return 64'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up by FRAC bits, then clip the accumulator into the DW-bit output range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 16,
    parameter int AW   = 41
) (
    input  logic signed [AW-1:0] acc_i,
    output logic signed [DW-1:0] data_o,
    output logic                 sat_o
);

    localparam logic [63:0] RC64 = round_const(FRAC);
    localparam logic [AW:0] RC   = RC64[AW:0];

    logic signed [AW:0]      sum;
    logic signed [AW:0]      shifted;
    logic        [AW-DW+1:0] hi;

    always_comb begin
        // One guard bit so adding the rounding constant can never wrap.
        sum     = {acc_i[AW-1], acc_i} + RC;
        shifted = sum >>> FRAC;
        hi      = shifted[AW:DW-1];
        sat_o   = (|hi) && !(&hi);
        if (!sat_o) begin
            data_o = shifted[DW-1:0];
        end else if (shifted[AW]) begin
            data_o = {1'b1, {(DW-1){1'b0}}};
        end else begin
            data_o = {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fir_serial.sv
// Serial FIR: one multiply-accumulate per cycle over a ring buffer of the last NTAPS samples.
//   state    | meaning
//   ST_IDLE  | ready for a sample; coefficient writes allowed
//   ST_MAC   | accumulating tap k, one tap per cycle
//   ST_ROUND | round/saturate acc into the output registers
module fir_serial
    import fir_pkg::*;
#(
    parameter int NTAPS = 32,
    parameter int DW    = 16,
    parameter int CW    = 20,
    parameter int FRAC  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DW-1:0]       in_data,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]       coef_data,
    output logic                       out_valid,
    output logic signed [DW-1:0]       out_data,
    output logic                       out_sat
);

    localparam int AW  = acc_width(DW, CW, NTAPS);
    localparam int PW  = $clog2(NTAPS);
    localparam int FW  = $clog2(NTAPS + 1);
    localparam int PRW = DW + CW;

    localparam logic [PW-1:0] LAST_K = PW'(NTAPS - 1);
    localparam logic [FW-1:0] FULL   = FW'(NTAPS);
    localparam logic [PW:0]   NT     = (PW + 1)'(NTAPS);

    fir_state_e           state_q, state_d;
    logic [PW-1:0]        k_q, k_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    logic signed [DW-1:0] buf_q  [NTAPS];
    logic signed [CW-1:0] coef_q [NTAPS];

    logic                 buf_we;
    logic                 coef_wr;
    logic [PW:0]          idx_wide;
    logic [PW-1:0]        tap_idx;
    logic signed [DW-1:0] x_sel;
    logic signed [CW-1:0] c_sel;
    logic signed [PRW-1:0] prod;
    logic signed [DW-1:0] rs_data;
    logic                 rs_sat;

    fir_round_sat #(
        .DW   (DW),
        .FRAC (FRAC),
        .AW   (AW)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // Tap k reads the sample k steps older than the newest one, wrapping modulo NTAPS.
    always_comb begin
        idx_wide = (wr_ptr_q >= k_q) ? {1'b0, wr_ptr_q - k_q}
                                     : {1'b0, wr_ptr_q} + NT - {1'b0, k_q};
        tap_idx  = idx_wide[PW-1:0];
        x_sel    = buf_q[tap_idx];
        c_sel    = coef_q[k_q];
        prod     = PRW'(x_sel) * PRW'(c_sel);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        in_ready    = 1'b0;
        buf_we      = 1'b0;
        coef_wr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_we  = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    fill_d  = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
                    state_d = ST_MAC;
                end else if (coef_we && ({1'b0, coef_addr} < NT)) begin
                    coef_wr = 1'b1;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + AW'(prod);
                if (k_q == LAST_K) begin
                    state_d = ST_ROUND;
                end else begin
                    k_d = k_q + PW'(1);
                end
            end
            ST_ROUND: begin
                // Until the ring holds NTAPS real samples the result is discarded.
                if (fill_q == FULL) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rs_data;
                    out_sat_d   = rs_sat;
                end
                wr_ptr_d = (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + PW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                buf_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (buf_we) begin
                buf_q[wr_ptr_q] <= in_data;
            end
            if (coef_wr) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_serial.sv
// Directed bench for fir_serial with a sample-history reference model checked every cycle.
module tb_fir_serial;

    localparam int NTAPS = 4;
    localparam int DW    = 16;
    localparam int CW    = 20;
    localparam int FRAC  = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic          coef_we   = 1'b0;
    logic [1:0]    coef_addr = '0;
    logic [CW-1:0] coef_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sat;

    int checks   = 0;
    int failures = 0;

    fir_serial #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .CW    (CW),
        .FRAC  (FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // Reference model: newest sample at m_hist[0], time measured in rising edges.
    longint        m_coef [NTAPS];
    longint        m_hist [NTAPS];
    int            m_fill       = 0;
    int            e            = 0;
    int            idle_from    = 0;
    int            due          = -1;
    logic [DW-1:0] pend_data    = '0;
    logic          pend_sat     = 1'b0;
    logic [DW-1:0] last_data    = '0;
    logic          last_sat     = 1'b0;
    bit            accepted_now = 1'b0;
    int            acc_edges[$];
    logic [DW:0]   cap[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic void model_out(input longint y, output logic [DW-1:0] d, output logic s);
        longint r;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (DW - 1)) - 1;
        minv = -(longint'(1) <<< (DW - 1));
        r = (y + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        s = 1'b0;
        if (r > maxv) begin
            r = maxv;
            s = 1'b1;
        end else if (r < minv) begin
            r = minv;
            s = 1'b1;
        end
        d = r[DW-1:0];
    endfunction

    initial begin
        for (int i = 0; i < NTAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
    end

    always @(posedge clk) begin
        longint y;
        e++;
        accepted_now = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                m_coef[i] = 0;
                m_hist[i] = 0;
            end
            m_fill    = 0;
            idle_from = 0;
            due       = -1;
            last_data = '0;
            last_sat  = 1'b0;
        end else begin
            if (e == due) begin
                last_data = pend_data;
                last_sat  = pend_sat;
            end
            if (in_valid && e >= idle_from) begin
                accepted_now = 1'b1;
                acc_edges.push_back(e);
                for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = longint'($signed(in_data));
                if (m_fill < NTAPS) m_fill++;
                y = 0;
                for (int i = 0; i < NTAPS; i++) y += m_coef[i] * m_hist[i];
                idle_from = e + NTAPS + 2;
                if (m_fill == NTAPS) begin
                    due = e + NTAPS + 1;
                    model_out(y, pend_data, pend_sat);
                end
            end else if (coef_we && e >= idle_from && int'(coef_addr) < NTAPS) begin
                m_coef[coef_addr] = longint'($signed(coef_data));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("out_valid", 64'(out_valid), 64'(rst_n && e == due));
        check("out_data", 64'(out_data), 64'(last_data));
        check("out_sat", 64'(out_sat), 64'(last_sat));
        if (rst_n) check("in_ready", 64'(in_ready), 64'(e + 1 >= idle_from));
        if (out_valid === 1'b1) cap.push_back({out_sat, out_data});
    end

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (accepted_now) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_timeout: sample %0h not accepted, got no acceptance required one within 20 cycles", d);
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [CW-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic drain();
        repeat (NTAPS + 4) @(negedge clk);
    endtask

    function automatic logic [DW:0] cap_at(input int i);
        if (cap.size() > i) return cap[i];
        return '1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Impulse response
        write_coef(2'd0, 20'h10000);
        write_coef(2'd1, 20'h08000);
        write_coef(2'd2, 20'h04000);
        write_coef(2'd3, 20'h02000);
        cap.delete();
        send(16'h0000); send(16'h0000); send(16'h0000); send(16'h1000);
        send(16'h0000); send(16'h0000); send(16'h0000);
        drain();
        check("impulse_count", 64'(cap.size()), 64'd4);
        check("impulse_y0", 64'(cap_at(0)), 64'h01000);
        check("impulse_y1", 64'(cap_at(1)), 64'h00800);
        check("impulse_y2", 64'(cap_at(2)), 64'h00400);
        check("impulse_y3", 64'(cap_at(3)), 64'h00200);

        // Saturation both directions
        for (int i = 0; i < NTAPS; i++) write_coef(2'(i), 20'h10000);
        cap.delete();
        for (int i = 0; i < 4; i++) send(16'h7FFF);
        drain();
        check("sat_pos", 64'(cap_at(3)), 64'h17FFF);
        cap.delete();
        for (int i = 0; i < 4; i++) send(16'h8000);
        drain();
        check("sat_neg", 64'(cap_at(3)), 64'h18000);

        // Rounding half up
        write_coef(2'd0, 20'h08000);
        for (int i = 1; i < NTAPS; i++) write_coef(2'(i), 20'h00000);
        for (int i = 0; i < 4; i++) send(16'h0000);
        drain();
        cap.delete();
        send(16'd3);
        send(16'hFFFD);
        drain();
        check("round_pos3", 64'(cap_at(0)), 64'h00002);
        check("round_neg3", 64'(cap_at(1)), 64'h0FFFF);

        // Back-to-back handshake
        acc_edges.delete();
        cap.delete();
        for (int i = 1; i <= 5; i++) send(16'(i * 256));
        drain();
        check("hs_count", 64'(acc_edges.size()), 64'd5);
        for (int i = 0; i + 1 < acc_edges.size(); i++)
            check("hs_spacing", 64'(acc_edges[i+1] - acc_edges[i]), 64'd6);
        check("hs_last", 64'(cap_at(4)), 64'h00280);

        // Coefficient write while busy is dropped, same write when idle lands
        cap.delete();
        send(16'd3);
        write_coef(2'd0, 20'h10000);
        drain();
        check("coef_busy_ignored", 64'(cap_at(0)), 64'h00002);
        write_coef(2'd0, 20'h10000);
        send(16'd3);
        drain();
        check("coef_idle_applied", 64'(cap_at(1)), 64'h00003);

        // Reset in the middle of a MAC
        send(16'h4000);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_data", 64'(out_data), 64'd0);
        check("abort_sat", 64'(out_sat), 64'd0);
        rst_n = 1'b1;
        cap.delete();
        send(16'h1111); send(16'h2222); send(16'h3333);
        drain();
        check("abort_refill", 64'(cap.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
